// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator sequencer: widths, fixed-point
// constants and the controller state encoding.
package acc_pkg;

  localparam int DATA_W    = 13;
  localparam int ACC_W     = 21;
  localparam int FRAC_BITS = 4;
  localparam int TMR_W     = 3;

  localparam logic signed [DATA_W-1:0] Q_ONE = 13'sd16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ACCUM = 3'd2,
    ST_DRAIN = 3'd3,
    ST_OUT   = 3'd4
  } state_e;

endpackage

// File: rtl/accumulator_seq_ctrl_if.sv
// Sample stream in and window-sum stream out, both valid/ready.
// master = source/sink side, slave = controller side.
interface accumulator_seq_ctrl_if #(
  parameter int DATA_W = acc_pkg::DATA_W,
  parameter int ACC_W  = acc_pkg::ACC_W
) ();

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ACC_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/acc_seq_timer.sv
// Loadable down-counter; loading N keeps done low for N cycles, so a state
// that exits on done lasts N+1 cycles.
module acc_seq_timer #(
  parameter int W = acc_pkg::TMR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/accumulator_seq_ctrl.sv
// Window sequencer for the pipelined fixed-point accumulator: clears it,
// feeds exactly len_q samples, flushes the pipeline and hands out the sum.
module accumulator_seq_ctrl #(
  parameter int DATA_W = acc_pkg::DATA_W,
  parameter int ACC_W  = acc_pkg::ACC_W,
  parameter int LEN_W  = 8,
  parameter int LAT    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   cont,
  input  logic [LEN_W-1:0]       cfg_len,
  accumulator_seq_ctrl_if.slave  bus,
  output logic                   acc_ce,
  output logic                   acc_rst,
  output logic [DATA_W-1:0]      acc_a,
  input  logic [ACC_W-1:0]       acc_sum,
  output logic                   busy
);

  import acc_pkg::*;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               acc_ce_q, acc_ce_d;
  logic               acc_rst_q, acc_rst_d;
  logic [DATA_W-1:0]  acc_a_q, acc_a_d;
  logic [ACC_W-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               accept;
  logic               tmr_load;
  logic               tmr_done;

  acc_seq_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (TMR_W'(LAT)),
    .done_o     (tmr_done)
  );

  assign accept = bus.in_valid && (state_q == ST_ACCUM);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    tmr_load    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d    = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
          state_d  = ST_CLEAR;
          tmr_load = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (tmr_done) begin
          state_d = ST_ACCUM;
          cnt_d   = '0;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) begin
            state_d  = ST_DRAIN;
            tmr_load = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        // The done cycle is the capture cycle: the last sample has settled.
        if (tmr_done) begin
          out_data_d  = acc_sum;
          out_valid_d = 1'b1;
          state_d     = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          if (cont) begin
            state_d  = ST_CLEAR;
            tmr_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Accumulator controls are registered, so they are decoded from the
    // upcoming state to line up with it.
    acc_rst_d = (state_d == ST_IDLE) || (state_d == ST_CLEAR);
    acc_ce_d  = (state_d == ST_CLEAR) || accept ||
                ((state_q == ST_DRAIN) && !tmr_done);
    acc_a_d   = accept ? bus.in_data : '0;
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      acc_ce_q    <= 1'b0;
      acc_rst_q   <= 1'b1;
      acc_a_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      acc_ce_q    <= acc_ce_d;
      acc_rst_q   <= acc_rst_d;
      acc_a_q     <= acc_a_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_ACCUM);
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign acc_ce        = acc_ce_q;
  assign acc_rst       = acc_rst_q;
  assign acc_a         = acc_a_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_accumulator_seq_ctrl.sv
// Bench for accumulator_seq_ctrl paired with a two-stage accumulator model;
// expected window sums go into a queue checked by an output monitor.
module tb_accumulator_seq_ctrl;

  localparam int DATA_W = 13;
  localparam int ACC_W  = 21;
  localparam int LEN_W  = 8;
  localparam int LAT    = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             cont;
  logic [LEN_W-1:0] cfg_len;
  logic             acc_ce;
  logic             acc_rst;
  logic [DATA_W-1:0] acc_a;
  logic [ACC_W-1:0] acc_sum;
  logic             busy;

  int n_checks = 0;
  int n_pass   = 0;
  logic [ACC_W-1:0] exp_q[$];

  accumulator_seq_ctrl_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

  accumulator_seq_ctrl #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W), .LAT(LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .cont    (cont),
    .cfg_len (cfg_len),
    .bus     (bus.slave),
    .acc_ce  (acc_ce),
    .acc_rst (acc_rst),
    .acc_a   (acc_a),
    .acc_sum (acc_sum),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Accumulator with LAT=2: operand register, then the sum register.
  logic [DATA_W-1:0] m_pipe = '0;
  logic [ACC_W-1:0]  m_sum  = '0;
  always @(posedge clk) begin
    if (acc_rst) begin
      m_pipe <= '0;
      m_sum  <= '0;
    end else if (acc_ce) begin
      m_pipe <= acc_a;
      m_sum  <= m_sum + {{(ACC_W-DATA_W){m_pipe[DATA_W-1]}}, m_pipe};
    end
  end
  assign acc_sum = m_sum;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: every cycle out_valid is up, out_data must equal the queue head.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL out_unexpected: got %0d expected no result", bus.out_data);
      end else begin
        check("out_data", 32'(bus.out_data), 32'(exp_q[0]));
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send(input int d, output int waited);
    bus.in_data  = d[DATA_W-1:0];
    bus.in_valid = 1'b1;
    waited = 0;
    while (!bus.in_ready && waited < 100) begin
      step();
      waited++;
    end
    check("send_accepted", 32'(bus.in_ready), 32'd1);
    step();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  initial begin
    int w;
    rst = 1'b0; start = 1'b0; cont = 1'b0; cfg_len = '0;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step(); step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_acc_rst", 32'(acc_rst), 32'd1);
    check("rst_acc_ce", 32'(acc_ce), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    step();

    // Window of four back-to-back samples: 1.0+2.0+3.0+1.5 = 7.5
    cfg_len = 8'd4;
    exp_q.push_back(21'd120);
    pulse_start();
    send(16, w); send(32, w); send(48, w); send(24, w);
    bus.in_valid = 1'b0;
    wait_idle();
    check("t1_acc_rst_idle", 32'(acc_rst), 32'd1);
    check("t1_in_ready_idle", 32'(bus.in_ready), 32'd0);

    // Signed samples with two-cycle gaps
    cfg_len = 8'd3;
    exp_q.push_back(21'd25);
    pulse_start();
    send(26, w);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin step(); check("t2_gap_ce", 32'(acc_ce), 32'd0); end
    send(-28, w);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin step(); check("t2_gap_ce", 32'(acc_ce), 32'd0); end
    send(27, w);
    bus.in_valid = 1'b0;
    wait_idle();

    // Continuous mode, first result back-pressured for five cycles
    cont = 1'b1; cfg_len = 8'd2; bus.out_ready = 1'b0;
    exp_q.push_back(21'd32);
    exp_q.push_back(21'd11);
    pulse_start();
    send(16, w); send(16, w);
    bus.in_valid = 1'b0;
    w = 0;
    while (!bus.out_valid && w < 100) begin step(); w++; end
    check("t3_out_valid_seen", 32'(bus.out_valid), 32'd1);
    bus.in_data = 13'd8; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t3_stall_in_ready", 32'(bus.in_ready), 32'd0);
      step();
    end
    bus.out_ready = 1'b1;
    send(8, w);
    check("t3_clear_wait", 32'(w), 32'(LAT + 2));
    send(3, w);
    bus.in_valid = 1'b0;
    cont = 1'b0;
    wait_idle();

    // Zero length acts as one; start and cfg_len changes mid-window ignored
    cfg_len = 8'd0;
    exp_q.push_back(21'd16);
    pulse_start();
    cfg_len = 8'd5;
    w = 0;
    while (!bus.in_ready && w < 100) begin step(); w++; end
    pulse_start();
    check("t4_busy_after_start", 32'(busy), 32'd1);
    check("t4_still_accum", 32'(bus.in_ready), 32'd1);
    send(16, w);
    bus.in_valid = 1'b0;
    wait_idle();

    // Reset in the middle of a window, then a clean window
    cfg_len = 8'd4;
    pulse_start();
    send(100, w); send(200, w);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    step();
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("t5_rst_acc_rst", 32'(acc_rst), 32'd1);
    check("t5_rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    step();
    exp_q.push_back(21'd10);
    pulse_start();
    send(1, w); send(2, w); send(3, w); send(4, w);
    bus.in_valid = 1'b0;
    wait_idle();

    step(); step();
    check("all_results_seen", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
